// File: rtl/dffmem_burst_if.sv
// Byte-stream command/data bundle between a host and dffmem_burst.
// Master = host side (drives input bytes, accepts output bytes).
// Slave = memory side (drives ready, read bytes and busy).
interface dffmem_burst_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       busy;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/dffmem_burst.sv
// DFF-array memory with a byte-stream burst port (cmd, LSB-first address, LSB-first words, auto-increment).
// Latency: write commits on the edge taking a word's last byte; first read byte valid the cycle after the last address byte.
// Backpressure: in_ready/out_valid are registered; out_data/out_valid hold while out_ready is low. Macro DFFMEM_CLEAR_EN adds array reset.
module dffmem_burst #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    dffmem_burst_if.slave bus
);
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int BPW    = DATA_W / 8;
    localparam int ABYTES = (ADDR_W + 7) / 8;
    localparam int BIW    = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int AIW    = (ABYTES > 1) ? $clog2(ABYTES) : 1;

    typedef enum logic [1:0] {S_CMD, S_ADDR, S_WDATA, S_RDATA} state_t;

    state_t              r_state;
    logic                r_in_rdy;
    logic                r_out_vld;
    logic                r_busy;
    logic                r_dir;
    logic [6:0]          r_len;
    logic [ADDR_W-1:0]   r_addr;
    logic [BIW-1:0]      r_bidx;
    logic [AIW-1:0]      r_abidx;
    logic [DATA_W-1:0]   r_stage;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    logic                w_in_acc;
    logic                w_out_acc;
    logic                w_bidx_last;
    logic                w_abidx_last;
    logic                w_commit;
    logic [ADDR_W-1:0]   w_addr_new;
    logic [DATA_W-1:0]   w_word;

    assign w_in_acc     = bus.in_valid && r_in_rdy;
    assign w_out_acc    = bus.out_ready && r_out_vld;
    assign w_bidx_last  = (r_bidx == BIW'(BPW - 1));
    assign w_abidx_last = (r_abidx == AIW'(ABYTES - 1));
    assign w_commit     = w_in_acc && (r_state == S_WDATA) && w_bidx_last;

    assign bus.in_ready  = r_in_rdy;
    assign bus.out_valid = r_out_vld;
    assign bus.busy      = r_busy;
    assign bus.out_data  = r_out_vld ? r_mem[r_addr][{r_bidx, 3'b000} +: 8] : 8'h00;

    // Merge the incoming address byte into its slot; bits beyond ADDR_W fall away.
    always_comb begin
        w_addr_new = r_addr;
        for (int i = 0; i < ADDR_W; i++) begin
            if (AIW'(i / 8) == r_abidx) begin
                w_addr_new[i] = bus.in_data[i % 8];
            end
        end
    end

    // Full word to commit: staged low bytes plus the byte arriving now.
    always_comb begin
        w_word = r_stage;
        w_word[{r_bidx, 3'b000} +: 8] = bus.in_data;
    end

    // Burst control FSM with registered handshake and busy outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_CMD;
            r_in_rdy  <= 1'b0;
            r_out_vld <= 1'b0;
            r_busy    <= 1'b0;
            r_dir     <= 1'b0;
            r_len     <= 7'd0;
            r_addr    <= '0;
            r_bidx    <= '0;
            r_abidx   <= '0;
            r_stage   <= '0;
        end else begin
            case (r_state)
                S_CMD: begin
                    r_in_rdy <= 1'b1;
                    if (w_in_acc) begin
                        r_dir   <= bus.in_data[7];
                        r_len   <= bus.in_data[6:0];
                        r_abidx <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (w_in_acc) begin
                        r_addr <= w_addr_new;
                        if (w_abidx_last) begin
                            r_abidx <= '0;
                            r_bidx  <= '0;
                            if (r_dir) begin
                                r_state <= S_WDATA;
                            end else begin
                                r_state   <= S_RDATA;
                                r_in_rdy  <= 1'b0;
                                r_out_vld <= 1'b1;
                            end
                        end else begin
                            r_abidx <= r_abidx + AIW'(1);
                        end
                    end
                end
                S_WDATA: begin
                    if (w_in_acc) begin
                        r_stage[{r_bidx, 3'b000} +: 8] <= bus.in_data;
                        if (w_bidx_last) begin
                            r_bidx <= '0;
                            r_addr <= r_addr + ADDR_W'(1);
                            if (r_len == 7'd0) begin
                                r_state <= S_CMD;
                                r_busy  <= 1'b0;
                            end else begin
                                r_len <= r_len - 7'd1;
                            end
                        end else begin
                            r_bidx <= r_bidx + BIW'(1);
                        end
                    end
                end
                S_RDATA: begin
                    if (w_out_acc) begin
                        if (w_bidx_last) begin
                            r_bidx <= '0;
                            r_addr <= r_addr + ADDR_W'(1);
                            if (r_len == 7'd0) begin
                                r_state   <= S_CMD;
                                r_out_vld <= 1'b0;
                                r_in_rdy  <= 1'b1;
                                r_busy    <= 1'b0;
                            end else begin
                                r_len <= r_len - 7'd1;
                            end
                        end else begin
                            r_bidx <= r_bidx + BIW'(1);
                        end
                    end
                end
                default: begin
                    r_state <= S_CMD;
                end
            endcase
        end
    end

`ifdef DFFMEM_CLEAR_EN
    // Word array, cleared by reset; a word lands only when its last byte arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_commit) begin
            r_mem[r_addr] <= w_word;
        end
    end
`else
    // Word array without reset so contents survive a control reset; whole words only.
    always_ff @(posedge clk) begin
        if (w_commit) begin
            r_mem[r_addr] <= w_word;
        end
    end
`endif

endmodule
